// File: rtl/tcu_sweep_ctrl_pkg.sv
// Shared definitions for the TCU sweep sequencer: entry layout, state codes,
// and the entry validity rule.
package tcu_sweep_ctrl_pkg;

  localparam int TCU_W = 6;
  localparam int CFG_W = 4 * TCU_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Member order matches cfg_wdata: delay0 occupies the top bits.
  typedef struct packed {
    logic [TCU_W-1:0] delay0;
    logic [TCU_W-1:0] width0;
    logic [TCU_W-1:0] delay1;
    logic [TCU_W-1:0] width1;
  } tcu_entry_t;

  // A pulse must end inside the 6-bit compare range, so delay+width is
  // formed one bit wider to catch the wrap.
  function automatic logic entry_valid(input tcu_entry_t e);
    logic [TCU_W:0] end0;
    logic [TCU_W:0] end1;
    end0 = {1'b0, e.delay0} + {1'b0, e.width0};
    end1 = {1'b0, e.delay1} + {1'b0, e.width1};
    return (e.width0 != '0) && (e.width1 != '0) &&
           (end0 <= 7'd63) && (end1 <= 7'd63);
  endfunction

endpackage

// File: rtl/tcu_cfg_table.sv
// DEPTH x 24-bit entry table: one synchronous write port, combinational read.
import tcu_sweep_ctrl_pkg::*;

module tcu_cfg_table #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk_in,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [CFG_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [CFG_W-1:0] rdata
);

  logic [CFG_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tcu_sweep_ctrl.sv
// Sequencer stepping a TCU0/TCU1 pair through a table of delay/width entries.
// Optional TCU_SWEEP_LOOP_EN adds loop_mode (restart at entry 0 until abort).
import tcu_sweep_ctrl_pkg::*;

module tcu_sweep_ctrl #(
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int DW_W     = 16,
  parameter int LOAD_CYC = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CFG_W-1:0] cfg_wdata,
  input  logic [AW-1:0]    cfg_last,
  input  logic [DW_W-1:0]  dwell,
  input  logic             start,
  input  logic             abort,
  input  logic             frame_tick,
`ifdef TCU_SWEEP_LOOP_EN
  input  logic             loop_mode,
`endif
  output logic             tcu_arm,
  output logic [TCU_W-1:0] tcu_delay0,
  output logic [TCU_W-1:0] tcu_width0,
  output logic [TCU_W-1:0] tcu_delay1,
  output logic [TCU_W-1:0] tcu_width1,
  output logic [AW-1:0]    cur_idx,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             err_skip
);

  localparam int LCW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(LOAD_CYC - 1);

  logic [2:0]       state;
  logic [LCW-1:0]   load_cnt;
  logic [DW_W-1:0]  tick_cnt;
  logic [DW_W-1:0]  dwell_last;
  logic [AW-1:0]    last_idx;
  logic [CFG_W-1:0] tbl_rdata;
  tcu_entry_t       entry;
  tcu_entry_t       tcu_q;
  logic             loop_on;
  logic [2:0]       adv_state;
  logic [AW-1:0]    adv_idx;
  logic             adv_done;

`ifdef TCU_SWEEP_LOOP_EN
  assign loop_on = loop_mode;
`else
  assign loop_on = 1'b0;
`endif

  // Writes are locked out for the whole sweep so the applied entry is stable.
  tcu_cfg_table #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_table (
    .clk_in (clk_in),
    .we     (cfg_we & ~busy),
    .waddr  (cfg_addr),
    .wdata  (cfg_wdata),
    .raddr  (cur_idx),
    .rdata  (tbl_rdata)
  );

  assign entry = tcu_entry_t'(tbl_rdata);

  generate
    if (DEPTH < (1 << AW)) begin : g_clamp
      localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);
      assign last_idx = (cfg_last > LAST_MAX) ? LAST_MAX : cfg_last;
    end else begin : g_noclamp
      assign last_idx = cfg_last;
    end
  endgenerate

  assign dwell_last = (dwell == '0) ? '0 : dwell - 1'b1;

  // Where to go after finishing (or skipping) the current entry.
  always_comb begin
    adv_state = ST_CHECK;
    adv_idx   = cur_idx + 1'b1;
    adv_done  = 1'b0;
    if (cur_idx >= last_idx) begin
      if (loop_on) begin
        adv_idx = '0;
      end else begin
        adv_state = ST_DONE;
        adv_idx   = cur_idx;
        adv_done  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state    <= ST_IDLE;
      tcu_arm  <= 1'b0;
      tcu_q    <= '0;
      cur_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      err_skip <= 1'b0;
      load_cnt <= '0;
      tick_cnt <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if ((state != ST_IDLE) && abort) begin
        state   <= ST_IDLE;
        tcu_arm <= 1'b0;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state    <= ST_CHECK;
              cur_idx  <= '0;
              busy     <= 1'b1;
              err_skip <= 1'b0;
            end
          end
          ST_CHECK: begin
            if (entry_valid(entry)) begin
              state    <= ST_LOAD;
              tcu_q    <= entry;
              load_cnt <= '0;
            end else begin
              err_skip <= 1'b1;
              state    <= adv_state;
              cur_idx  <= adv_idx;
              done     <= adv_done;
            end
          end
          ST_LOAD: begin
            if (load_cnt == LOAD_LAST) begin
              state    <= ST_RUN;
              tcu_arm  <= 1'b1;
              tick_cnt <= '0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
          ST_RUN: begin
            if (frame_tick) begin
              if (tick_cnt == dwell_last) begin
                tcu_arm <= 1'b0;
                state   <= adv_state;
                cur_idx <= adv_idx;
                done    <= adv_done;
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state   <= ST_IDLE;
            tcu_arm <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tcu_delay0 = tcu_q.delay0;
  assign tcu_width0 = tcu_q.width0;
  assign tcu_delay1 = tcu_q.delay1;
  assign tcu_width1 = tcu_q.width1;

endmodule

// File: tb/tb_tcu_sweep_ctrl.sv
// Self-checking bench for tcu_sweep_ctrl against a table-level sweep model.
module tb_tcu_sweep_ctrl;

  localparam int DEPTH    = 8;
  localparam int AW       = 3;
  localparam int DW_W     = 16;
  localparam int LOAD_CYC = 4;

  logic            clk_in = 1'b0;
  logic            reset;
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [23:0]     cfg_wdata;
  logic [AW-1:0]   cfg_last;
  logic [DW_W-1:0] dwell;
  logic            start;
  logic            abort;
  logic            frame_tick;
`ifdef TCU_SWEEP_LOOP_EN
  logic            loop_mode;
`endif
  logic            tcu_arm;
  logic [5:0]      tcu_delay0, tcu_width0, tcu_delay1, tcu_width1;
  logic [AW-1:0]   cur_idx;
  logic            busy, done, aborted, err_skip;
  logic [23:0]     fields;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] mdl [DEPTH];

  assign fields = {tcu_delay0, tcu_width0, tcu_delay1, tcu_width1};

  tcu_sweep_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .DW_W(DW_W), .LOAD_CYC(LOAD_CYC)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_last   (cfg_last),
    .dwell      (dwell),
    .start      (start),
    .abort      (abort),
    .frame_tick (frame_tick),
`ifdef TCU_SWEEP_LOOP_EN
    .loop_mode  (loop_mode),
`endif
    .tcu_arm    (tcu_arm),
    .tcu_delay0 (tcu_delay0),
    .tcu_width0 (tcu_width0),
    .tcu_delay1 (tcu_delay1),
    .tcu_width1 (tcu_width1),
    .cur_idx    (cur_idx),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .err_skip   (err_skip)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [23:0] mk(input int d0, input int w0, input int d1, input int w1);
    logic [5:0] a, b, c, d;
    a = d0[5:0]; b = w0[5:0]; c = d1[5:0]; d = w1[5:0];
    return {a, b, c, d};
  endfunction

  // Entry is usable when both widths are nonzero and neither pulse runs past 63.
  function automatic bit ref_valid(input logic [23:0] e);
    int d0, w0, d1, w1;
    d0 = int'(e[23:18]); w0 = int'(e[17:12]);
    d1 = int'(e[11:6]);  w1 = int'(e[5:0]);
    return (w0 != 0) && (w1 != 0) && (d0 + w0 <= 63) && (d1 + w1 <= 63);
  endfunction

  function automatic logic [23:0] rand_entry();
    int d0, w0, d1, w1;
    d0 = $urandom_range(0, 45); d1 = $urandom_range(0, 45);
    w0 = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 25);
    w1 = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 25);
    return mk(d0, w0, d1, w1);
  endfunction

  task automatic write_entry(input int addr, input logic [23:0] data);
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_wdata = data;
    step();
    cfg_we = 1'b0;
    mdl[addr] = data;
  endtask

  // Starts a sweep and follows it to completion, checking the sequence of
  // armed entries, load times, dwell tick counts, done and err_skip.
  task automatic run_sweep(input int last, input int dw, input int tick_pct,
                           input bit disturb, input string tag);
    int exp_q[$];
    int skip_q[$];
    bit exp_err;
    int dwe, s, k, low_run, win_ticks, done_cnt;
    bit prev_arm, prev_tick, prev_done, tick, finished;
    logic [23:0] cap, want;
    dwe = (dw == 0) ? 1 : dw;
    exp_err = 1'b0; s = 0;
    for (int i = 0; i <= last; i++) begin
      if (ref_valid(mdl[i])) begin
        exp_q.push_back(i); skip_q.push_back(s); s = 0;
      end else begin
        exp_err = 1'b1; s++;
      end
    end
    cfg_last = AW'(last); dwell = DW_W'(dw); start = 1'b1;
    step();
    start = 1'b0; cfg_we = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || err_skip !== 1'b0 || cur_idx !== '0) begin
      n_fail++;
      $display("FAIL %s start: busy=%b err_skip=%b cur_idx=%0d, expected 1 0 0", tag, busy, err_skip, cur_idx);
    end
    k = 0; low_run = 0; win_ticks = 0; done_cnt = 0; cap = '0;
    prev_arm = 1'b0; prev_tick = 1'b0; prev_done = 1'b0; finished = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      tick = ($urandom_range(0, 99) < tick_pct);
      frame_tick = tick;
      cfg_we = 1'b0; start = 1'b0;
      if (disturb && cyc == 0) begin
        cfg_we = 1'b1; start = 1'b1;
        cfg_addr = AW'($urandom_range(0, DEPTH - 1)); cfg_wdata = rand_entry();
      end
      if (tcu_arm && !prev_arm) begin
        n_checks++;
        if (k >= exp_q.size()) begin
          n_fail++;
          $display("FAIL %s rise: extra arm #%0d at cur_idx=%0d, expected %0d arms", tag, k, cur_idx, exp_q.size());
        end else begin
          want = mdl[exp_q[k]];
          if (fields !== want || cur_idx !== AW'(exp_q[k]) || low_run != LOAD_CYC + 1 + skip_q[k]) begin
            n_fail++;
            $display("FAIL %s rise #%0d: fields=%h idx=%0d low=%0d, expected %h %0d %0d", tag, k,
                     fields, cur_idx, low_run, want, exp_q[k], LOAD_CYC + 1 + skip_q[k]);
          end
        end
        cap = fields; win_ticks = 0; low_run = 0;
      end
      if (tcu_arm) begin
        n_checks++;
        if (fields !== cap) begin
          n_fail++;
          $display("FAIL %s hold: fields=%h while armed, expected %h", tag, fields, cap);
        end
        win_ticks += int'(tick);
      end
      if (!tcu_arm && prev_arm) begin
        n_checks++;
        if (win_ticks != dwe || !prev_tick) begin
          n_fail++;
          $display("FAIL %s dwell #%0d: ticks=%0d last_tick=%0d, expected %0d 1", tag, k, win_ticks, prev_tick, dwe);
        end
        k++;
      end
      if (busy && !tcu_arm) low_run++;
      if (done) begin
        done_cnt++;
        n_checks++;
        if (k != exp_q.size() || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s done: arms=%0d busy=%b, expected %0d 1", tag, k, busy, exp_q.size());
        end
      end
      if (!busy) begin
        finished = 1'b1;
        n_checks++;
        if (done_cnt != 1 || !prev_done || err_skip !== exp_err || k != exp_q.size() || tcu_arm !== 1'b0) begin
          n_fail++;
          $display("FAIL %s end: done_cnt=%0d prev_done=%0d err_skip=%b arms=%0d arm=%b, expected 1 1 %b %0d 0",
                   tag, done_cnt, prev_done, err_skip, k, tcu_arm, exp_err, exp_q.size());
        end
      end
      prev_arm = tcu_arm; prev_tick = tick; prev_done = done;
      if (!finished) step();
    end
    frame_tick = 1'b0; cfg_we = 1'b0; start = 1'b0;
    if (!finished) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: busy=%b after 4000 cycles, expected 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++;
    if ({tcu_arm, fields, cur_idx, busy, done, aborted, err_skip} !== '0) begin
      n_fail++;
      $display("FAIL reset: arm=%b fields=%h idx=%0d busy=%b done=%b aborted=%b err=%b, expected all 0",
               tcu_arm, fields, cur_idx, busy, done, aborted, err_skip);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    write_entry(0, mk(0, 2, 1, 2));
    write_entry(1, mk(3, 4, 5, 6));
    run_sweep(1, 2, 40, 1'b0, "basic");
  endtask

  task automatic test_skip();
    write_entry(0, mk(0, 0, 1, 2));
    write_entry(1, mk(7, 9, 2, 3));
    run_sweep(1, 1, 50, 1'b0, "skip_w0");
    write_entry(0, mk(40, 30, 1, 2));
    run_sweep(1, 3, 60, 1'b0, "skip_sum");
    write_entry(1, mk(10, 5, 60, 4));
    run_sweep(1, 1, 60, 1'b0, "skip_last");
    write_entry(0, mk(33, 30, 30, 33));
    write_entry(1, mk(1, 1, 2, 2));
    run_sweep(1, 0, 70, 1'b0, "edge63_dwell0");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < DEPTH; a++) write_entry(a, rand_entry());
      run_sweep($urandom_range(0, DEPTH - 1), $urandom_range(0, 3),
                $urandom_range(30, 100), 1'(r % 2), "random");
    end
  endtask

  task automatic test_abort(input bit in_run);
    bit seen;
    write_entry(0, mk(2, 3, 4, 5));
    write_entry(1, mk(6, 7, 8, 9));
    cfg_last = AW'(1); dwell = in_run ? DW_W'(1) : DW_W'(500); start = 1'b1;
    step();
    start = 1'b0;
    seen = !in_run;
    if (in_run) begin
      for (int i = 0; i < 40 && !seen; i++) begin
        step();
        seen = (tcu_arm === 1'b1);
      end
    end else begin
      step();
    end
    n_checks++;
    if (!seen || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_setup: armed=%0d busy=%b, expected 1 1", seen, busy);
    end
    abort = 1'b1; frame_tick = 1'b1;
    step();
    abort = 1'b0; frame_tick = 1'b0;
    n_checks++;
    if (aborted !== 1'b1 || tcu_arm !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: aborted=%b arm=%b busy=%b done=%b, expected 1 0 0 0", aborted, tcu_arm, busy, done);
    end
    step();
    n_checks++;
    if (aborted !== 1'b0 || busy !== 1'b0 || tcu_arm !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after: aborted=%b busy=%b arm=%b, expected 0 0 0", aborted, busy, tcu_arm);
    end
  endtask

  task automatic test_reset_mid_load();
    write_entry(0, mk(11, 12, 13, 14));
    write_entry(1, mk(0, 0, 0, 0));
    cfg_last = AW'(1); dwell = DW_W'(1); start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({tcu_arm, fields, cur_idx, busy, done, aborted, err_skip} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_load: arm=%b fields=%h idx=%0d busy=%b, expected all 0", tcu_arm, fields, cur_idx, busy);
    end
    run_sweep(1, 2, 50, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    write_entry(1, mk(5, 5, 5, 5));
    cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = mk(20, 10, 30, 8);
    mdl[0] = cfg_wdata;
    run_sweep(1, 1, 100, 1'b0, "wr_with_start");
    run_sweep(1, 2, 80, 1'b1, "b2b");
    run_sweep(0, 1, 90, 1'b0, "b2b_readback");
  endtask

`ifdef TCU_SWEEP_LOOP_EN
  task automatic test_loop();
    int rises, dones;
    bit prev;
    write_entry(0, mk(1, 2, 3, 4));
    loop_mode = 1'b1; cfg_last = '0; dwell = DW_W'(1); start = 1'b1;
    step();
    start = 1'b0; frame_tick = 1'b1;
    rises = 0; dones = 0; prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tcu_arm && !prev) begin
        rises++;
        n_checks++;
        if (fields !== mdl[0] || cur_idx !== '0) begin
          n_fail++;
          $display("FAIL loop_entry: fields=%h idx=%0d, expected %h 0", fields, cur_idx, mdl[0]);
        end
      end
      dones += int'(done);
      prev = tcu_arm;
      step();
    end
    n_checks++;
    if (rises < 3 || dones != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL loop: rises=%0d dones=%0d busy=%b, expected >=3 0 1", rises, dones, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0; frame_tick = 1'b0; loop_mode = 1'b0;
    n_checks++;
    if (aborted !== 1'b1 || busy !== 1'b0 || tcu_arm !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_abort: aborted=%b busy=%b arm=%b, expected 1 0 0", aborted, busy, tcu_arm);
    end
    step();
  endtask
`endif

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_last = '0;
    dwell = '0; start = 1'b0; abort = 1'b0; frame_tick = 1'b0;
`ifdef TCU_SWEEP_LOOP_EN
    loop_mode = 1'b0;
`endif
    test_reset();
    test_basic();
    test_skip();
    test_abort(1'b1);
    test_abort(1'b0);
    test_reset_mid_load();
    test_back_to_back();
    test_random();
`ifdef TCU_SWEEP_LOOP_EN
    test_loop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
